hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard and pipeline-control unit for the 5-stage MIPS core, successor to the current combinational hazard logic. Generates forwarding selects, load-use/branch stalls, pipeline flushes and the exception redirect PC. Adds a sequenced start/ready handshake for the multi-cycle multiply/divide unit (MDU), with a timeout and cancel-on-exception. Sits beside the datapath and drives every pipeline register's stall/flush enables.

## Interface
- REG_AW, 5: register-index width.
- PC_W, 32: PC width.
- EXC_VEC, 32'hBFC00380: exception entry address.
- ERET_CODE, 32'h0000000E: `excepttype` value meaning ERET; the redirect target is `epc`.
- MDU_TIMEOUT, 64: maximum BUSY cycles before forced release; ≥2.

- clk  in  1  clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- rsD, rtD  in  REG_AW  D-stage source registers.
- branchD, jrD  in  1  D-stage branch / jump-register.
- rsE, rtE, writeregE  in  REG_AW  E-stage sources and destination.
- regwriteE, memtoregE  in  1  E-stage write-enable / load.
- mduopE  in  1  E-stage instruction is MDU multiply/divide.
- mdu_ready  in  1  MDU result valid (pulse or level).
- writeregM  in  REG_AW;  regwriteM, memtoregM  in  1  M-stage.
- excepttype  in  32  M-stage exception code; 0 = none.
- epc  in  PC_W  return address for ERET.
- writeregW  in  REG_AW;  regwriteW  in  1  W-stage.
- forwardaD, forwardbD  out  1  D-stage compare operand from M.
- forwardaE, forwardbE  out  2  00 = regfile, 10 = M, 01 = W.
- stallF, stallD, stallE  out  1  stage hold.
- flushF, flushD, flushE, flushM, flushW  out  1  stage clear.
- newpc  out  PC_W  redirect target; valid while `flushF` is high.
- mdu_start  out  1  one-cycle MDU launch pulse.
- mdu_cancel  out  1  one-cycle MDU abort pulse.
- mdu_busy  out  1  FSM not IDLE.
- mdu_timeout  out  1  one-cycle pulse on forced release.

## Operation
- Register 0 never matches in any forwarding or stall comparison.
- **E-stage forwarding**
  - Forward from M (10) when the source equals `writeregM` and `regwriteM` is high.
  - Otherwise forward from W (01) when the source equals `writeregW` and `regwriteW` is high.
  - M has priority over W.
- **D-stage forwarding:** `forwardaD`/`forwardbD` = source equals `writeregM` and `regwriteM` is high.
- **Load-use stall:** `lwstall` = `memtoregE` & `rtE`≠0 & (`rtE`==`rsD` | `rtE`==`rtD`).
- **Branch stall:** `brstall` = (`branchD` | `jrD`) & ((`regwriteE` & `writeregE` matches `rsD`/`rtD`) | (`memtoregM` & `writeregM` matches `rsD`/`rtD`)).
- **MDU FSM:** states IDLE, BUSY, DONE.
  - IDLE & `mduopE` & no exception: `mdu_start`=1, go to BUSY.
  - BUSY & `mdu_ready`: go to DONE.
  - BUSY & counter reaches MDU_TIMEOUT−1: `mdu_timeout`=1, go to DONE.
  - DONE: unconditionally go to IDLE.
  - Counter clears on entry to BUSY and increments each BUSY cycle.
- `mdustall` = (IDLE & `mduopE`) | BUSY. It is 0 in DONE, so the MDU op leaves E at the end of DONE.
- **Stalls and flushes (no exception):**
  - `stallF` = `stallD` = `lwstall` | `brstall` | `mdustall`.
  - `stallE` = `mdustall`.
  - `flushE` = (`lwstall` | `brstall`) & ~`mdustall`.
  - All other flushes are 0.
- **Exception** (`excepttype`≠0) overrides everything in the same cycle:
  - All stalls are 0 and all five flushes are 1.
  - `newpc` = `epc` if `excepttype`==ERET_CODE, else EXC_VEC.
  - If the FSM is BUSY or DONE: `mdu_cancel`=1, FSM goes to IDLE next cycle, no `mdu_start`.
- `newpc` = 0 when there is no exception. It must never infer a latch.

## Timing
- Forwarding, stalls, flushes and `newpc` are combinational from inputs and FSM state. `mdu_start`, `mdu_cancel` and `mdu_timeout` are decoded from state.
- **MDU latency:** op in E at cycle t gives `mdu_start` at t, BUSY from t+1. `mdu_ready` at t+k gives DONE at t+k+1, and the op advances at the end of t+k+1.
- `mdu_ready` while IDLE or DONE is ignored.
- A back-to-back MDU op entering E after DONE starts a fresh handshake.
- **Reset:** FSM is IDLE and the counter is 0. All outputs are 0, except flushes, which follow `excepttype`.
- Reset asserted mid-BUSY returns to IDLE with no `mdu_cancel` pulse.

## Structure
- Shared package `hazard_pkg`:
  - FSM state encoding (IDLE=0, BUSY=1, DONE=2).
  - Forwarding select constants FWD_RF, FWD_M, FWD_W.
  - Default EXC_VEC and ERET_CODE.
- One sub-module, `mdu_seq`: contains the FSM and the timeout counter, width $clog2(MDU_TIMEOUT). Everything else is top-level combinational.

## Test plan
- `rsE`=3, `writeregM`=3 with `regwriteM`, and `writeregW`=3 with `regwriteW` → `forwardaE`=10. With `rsE`=0 → 00.
- `memtoregE`, `rtE`=5, `rsD`=5 → `stallF`/`stallD`/`flushE` high for 1 cycle. Same with `rtE`=0 → no stall.
- `mduopE` at t, `mdu_ready` at t+4 → `mdu_start` at t, `stallE` t..t+4, DONE at t+5, `mdu_busy` low at t+6.
- `mduopE` with no ready and MDU_TIMEOUT=8 → `mdu_timeout` pulses 8 cycles after the start cycle, then DONE, then IDLE.
- `excepttype`=1 while BUSY → all flushes 1, stalls 0, `newpc`=BFC00380, `mdu_cancel` 1 cycle, IDLE next cycle.
- `excepttype`=0000000E, `epc`=80001234 → `newpc`=80001234. Then `rst` mid-BUSY → IDLE and all MDU outputs 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/pipeline-control slice.
//   - MDU sequencer state encoding
//   - E-stage forwarding select codes
//   - default exception vector and ERET exception code
package hazard_pkg;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // forwardaE/forwardbE encodings
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  localparam logic [31:0] EXC_VEC_DEFAULT   = 32'hBFC00380;
  localparam logic [31:0] ERET_CODE_DEFAULT = 32'h0000000E;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle.
//   master : datapath side (drives stage fields, receives controls)
//   slave  : hazard unit side
// Stage fields: rsD/rtD/branchD/jrD, rsE/rtE/writeregE/regwriteE/memtoregE/
// mduopE, writeregM/regwriteM/memtoregM/excepttype/epc, writeregW/regwriteW,
// mdu_ready. Controls: forwarding selects, stalls, flushes, newpc, MDU handshake.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PC_W   = 32
);
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic              branchD, jrD, regwriteE, memtoregE, mduopE, mdu_ready;
  logic              regwriteM, memtoregM, regwriteW;
  logic [31:0]       excepttype;
  logic [PC_W-1:0]   epc;

  logic              forwardaD, forwardbD;
  logic [1:0]        forwardaE, forwardbE;
  logic              stallF, stallD, stallE;
  logic              flushF, flushD, flushE, flushM, flushW;
  logic [PC_W-1:0]   newpc;
  logic              mdu_start, mdu_cancel, mdu_busy, mdu_timeout;

  modport master (
    output rsD, rtD, branchD, jrD, rsE, rtE, writeregE, regwriteE, memtoregE,
           mduopE, mdu_ready, writeregM, regwriteM, memtoregM, excepttype, epc,
           writeregW, regwriteW,
    input  forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, stallE,
           flushF, flushD, flushE, flushM, flushW, newpc,
           mdu_start, mdu_cancel, mdu_busy, mdu_timeout
  );

  modport slave (
    input  rsD, rtD, branchD, jrD, rsE, rtE, writeregE, regwriteE, memtoregE,
           mduopE, mdu_ready, writeregM, regwriteM, memtoregM, excepttype, epc,
           writeregW, regwriteW,
    output forwardaD, forwardbD, forwardaE, forwardbE, stallF, stallD, stallE,
           flushF, flushD, flushE, flushM, flushW, newpc,
           mdu_start, mdu_cancel, mdu_busy, mdu_timeout
  );
endinterface

// File: rtl/mdu_seq.sv
// MDU start/ready sequencer with timeout and cancel-on-exception.
//   clk, rst     : clock, synchronous active-high reset
//   mduop_i      : MDU op sitting in E
//   ready_i      : MDU result valid (only honoured while BUSY)
//   exc_i        : exception in M this cycle
//   start_o      : launch pulse, cancel_o : abort pulse
//   timeout_o    : forced-release pulse, busy_o : not IDLE
//   mdustall_o   : hold the pipe while the op is outstanding
module mdu_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic mduop_i,
  input  logic ready_i,
  input  logic exc_i,
  output logic start_o,
  output logic cancel_o,
  output logic timeout_o,
  output logic busy_o,
  output logic mdustall_o
);
  localparam int unsigned     CW       = $clog2(MDU_TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(MDU_TIMEOUT - 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start, cancel, timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    cancel  = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      MDU_IDLE: begin
        if (mduop_i && !exc_i) begin
          start   = 1'b1;
          cnt_d   = '0;
          state_d = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        // a result arriving on the last allowed cycle counts as a normal completion
        if (exc_i) begin
          cancel  = 1'b1;
          state_d = MDU_IDLE;
        end else if (ready_i) begin
          state_d = MDU_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = MDU_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MDU_DONE: begin
        cancel  = exc_i;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // outputs are held low during reset so a mid-BUSY reset never pulses cancel
  assign start_o    = start   && !rst;
  assign cancel_o   = cancel  && !rst;
  assign timeout_o  = timeout && !rst;
  assign busy_o     = (state_q != MDU_IDLE) && !rst;
  assign mdustall_o = (((state_q == MDU_IDLE) && mduop_i) || (state_q == MDU_BUSY)) && !rst;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core.
//   clk, rst : clock, synchronous active-high reset
//   hif      : hazard_ctrl_if.slave -- stage fields in; forwarding selects,
//              stall/flush enables, exception redirect PC and MDU handshake out
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned     REG_AW      = 5,
  parameter int unsigned     PC_W        = 32,
  parameter logic [PC_W-1:0] EXC_VEC     = PC_W'(EXC_VEC_DEFAULT),
  parameter logic [31:0]     ERET_CODE   = ERET_CODE_DEFAULT,
  parameter int unsigned     MDU_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hif
);
  // register 0 is hardwired, so it never creates a dependency
  function automatic logic hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] wm, input logic rwm,
                                       input logic [REG_AW-1:0] ww, input logic rww);
    if (rwm && hit(src, wm)) return FWD_M;
    if (rww && hit(src, ww)) return FWD_W;
    return FWD_RF;
  endfunction

  logic exc, lwstall, brstall, mdustall;

  assign exc     = (hif.excepttype != '0);
  assign lwstall = hif.memtoregE && (hit(hif.rtE, hif.rsD) || hit(hif.rtE, hif.rtD));
  assign brstall = (hif.branchD || hif.jrD) &&
                   ((hif.regwriteE && (hit(hif.writeregE, hif.rsD) || hit(hif.writeregE, hif.rtD))) ||
                    (hif.memtoregM && (hit(hif.writeregM, hif.rsD) || hit(hif.writeregM, hif.rtD))));

  mdu_seq #(.MDU_TIMEOUT(MDU_TIMEOUT)) u_mdu_seq (
    .clk       (clk),
    .rst       (rst),
    .mduop_i   (hif.mduopE),
    .ready_i   (hif.mdu_ready),
    .exc_i     (exc),
    .start_o   (hif.mdu_start),
    .cancel_o  (hif.mdu_cancel),
    .timeout_o (hif.mdu_timeout),
    .busy_o    (hif.mdu_busy),
    .mdustall_o(mdustall)
  );

  always_comb begin
    hif.forwardaD = 1'b0;
    hif.forwardbD = 1'b0;
    hif.forwardaE = FWD_RF;
    hif.forwardbE = FWD_RF;
    hif.stallF    = 1'b0;
    hif.stallD    = 1'b0;
    hif.stallE    = 1'b0;
    hif.newpc     = '0;
    // flushes track the exception even while reset is held
    hif.flushF    = exc;
    hif.flushD    = exc;
    hif.flushE    = exc;
    hif.flushM    = exc;
    hif.flushW    = exc;
    if (!rst) begin
      hif.forwardaD = hif.regwriteM && hit(hif.rsD, hif.writeregM);
      hif.forwardbD = hif.regwriteM && hit(hif.rtD, hif.writeregM);
      hif.forwardaE = fwd_e(hif.rsE, hif.writeregM, hif.regwriteM, hif.writeregW, hif.regwriteW);
      hif.forwardbE = fwd_e(hif.rtE, hif.writeregM, hif.regwriteM, hif.writeregW, hif.regwriteW);
      if (exc) begin
        hif.newpc = (hif.excepttype == ERET_CODE) ? hif.epc : EXC_VEC;
      end else begin
        hif.stallF = lwstall || brstall || mdustall;
        hif.stallD = lwstall || brstall || mdustall;
        hif.stallE = mdustall;
        // a held E stage must keep its MDU op, so no bubble is inserted then
        hif.flushE = (lwstall || brstall) && !mdustall;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  hazard_ctrl_if #(.REG_AW(5), .PC_W(32)) hif ();

  hazard_ctrl #(.REG_AW(5), .PC_W(32), .MDU_TIMEOUT(T)) dut (
    .clk(clk),
    .rst(rst),
    .hif(hif)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // bit layout: faD fbD faE[2] fbE[2] stF stD stE flF flD flE flM flW start cancel busy timeout
  function automatic logic [17:0] obs();
    return {hif.forwardaD, hif.forwardbD, hif.forwardaE, hif.forwardbE,
            hif.stallF, hif.stallD, hif.stallE,
            hif.flushF, hif.flushD, hif.flushE, hif.flushM, hif.flushW,
            hif.mdu_start, hif.mdu_cancel, hif.mdu_busy, hif.mdu_timeout};
  endfunction

  // reference: forwarding source for an E operand
  function automatic logic [1:0] ref_fwd(input logic [4:0] s);
    if (s == 5'd0) return 2'b00;
    if (hif.regwriteM && s == hif.writeregM) return 2'b10;
    if (hif.regwriteW && s == hif.writeregW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic depends(input logic [4:0] w);
    return (w != 5'd0) && (w == hif.rsD || w == hif.rtD);
  endfunction

  // reference for the whole control vector with no MDU activity and reset low
  function automatic logic [17:0] ref_pipe();
    logic ex, lw, br, s, da, db;
    ex = (hif.excepttype != 32'd0);
    lw = hif.memtoregE && depends(hif.rtE);
    br = (hif.branchD || hif.jrD) &&
         ((hif.regwriteE && depends(hif.writeregE)) || (hif.memtoregM && depends(hif.writeregM)));
    s  = !ex && (lw || br);
    da = hif.regwriteM && hif.rsD != 5'd0 && hif.rsD == hif.writeregM;
    db = hif.regwriteM && hif.rtD != 5'd0 && hif.rtD == hif.writeregM;
    return {da, db, ref_fwd(hif.rsE), ref_fwd(hif.rtE), s, s, 1'b0,
            ex, ex, (ex || s), ex, ex, 4'b0000};
  endfunction

  function automatic logic [31:0] ref_newpc();
    if (hif.excepttype == 32'd0) return 32'd0;
    if (hif.excepttype == 32'h0000000E) return hif.epc;
    return 32'hBFC00380;
  endfunction

  task automatic clear_inputs();
    hif.rsD = '0; hif.rtD = '0; hif.rsE = '0; hif.rtE = '0;
    hif.writeregE = '0; hif.writeregM = '0; hif.writeregW = '0;
    hif.branchD = 1'b0; hif.jrD = 1'b0; hif.regwriteE = 1'b0; hif.memtoregE = 1'b0;
    hif.mduopE = 1'b0; hif.mdu_ready = 1'b0; hif.regwriteM = 1'b0; hif.memtoregM = 1'b0;
    hif.regwriteW = 1'b0; hif.excepttype = '0; hif.epc = '0;
  endtask

  task automatic rand_pipe();
    hif.rsD = 5'($urandom_range(0, 3)); hif.rtD = 5'($urandom_range(0, 3));
    hif.rsE = 5'($urandom_range(0, 3)); hif.rtE = 5'($urandom_range(0, 3));
    hif.writeregE = 5'($urandom_range(0, 3));
    hif.writeregM = 5'($urandom_range(0, 3));
    hif.writeregW = 5'($urandom_range(0, 3));
    hif.branchD = 1'($urandom_range(0, 1)); hif.jrD = 1'($urandom_range(0, 1));
    hif.regwriteE = 1'($urandom_range(0, 1)); hif.memtoregE = 1'($urandom_range(0, 1));
    hif.regwriteM = 1'($urandom_range(0, 1)); hif.memtoregM = 1'($urandom_range(0, 1));
    hif.regwriteW = 1'($urandom_range(0, 1));
    hif.mdu_ready = 1'($urandom_range(0, 1));
    hif.epc = $urandom;
    case ($urandom_range(0, 5))
      0: hif.excepttype = 32'h0000000E;
      1: hif.excepttype = $urandom_range(1, 32'h7FFF_FFFF);
      default: hif.excepttype = '0;
    endcase
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] exp;
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      rand_pipe();
      hif.mduopE = 1'($urandom_range(0, 1));
      hif.excepttype = (i % 2 == 1) ? 32'($urandom_range(1, 15)) : 32'd0;
      @(negedge clk);
      exp = (hif.excepttype != 32'd0) ? 18'h001F0 : 18'h00000;
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("FAIL reset_outputs[%0d]: got %h expected %h", i, obs(), exp);
      end
      tests_run++;
      if (hif.newpc !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_newpc[%0d]: got %h expected 00000000", i, hif.newpc);
      end
      next_cycle();
    end
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    tests_run++;
    if (obs() !== 18'h0 || hif.newpc !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_release: got %h/%h expected 00000/00000000", obs(), hif.newpc);
    end
    next_cycle();
  endtask

  task automatic test_forwarding();
    logic [17:0] exp;
    clear_inputs();
    hif.rsE = 5'd3; hif.writeregM = 5'd3; hif.regwriteM = 1'b1;
    hif.writeregW = 5'd3; hif.regwriteW = 1'b1;
    @(negedge clk);
    tests_run++;
    if (hif.forwardaE !== 2'b10) begin
      tests_failed++;
      $display("FAIL fwd_m_priority: got %b expected 10", hif.forwardaE);
    end
    next_cycle();
    hif.regwriteM = 1'b0;
    @(negedge clk);
    tests_run++;
    if (hif.forwardaE !== 2'b01) begin
      tests_failed++;
      $display("FAIL fwd_w: got %b expected 01", hif.forwardaE);
    end
    next_cycle();
    hif.rsE = 5'd0; hif.regwriteM = 1'b1; hif.writeregM = 5'd0; hif.writeregW = 5'd0;
    @(negedge clk);
    tests_run++;
    if (hif.forwardaE !== 2'b00) begin
      tests_failed++;
      $display("FAIL fwd_r0: got %b expected 00", hif.forwardaE);
    end
    next_cycle();
    for (int i = 0; i < 150; i++) begin
      rand_pipe();
      @(negedge clk);
      exp = ref_pipe();
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("FAIL pipe_rand[%0d]: got %h expected %h", i, obs(), exp);
      end
      tests_run++;
      if (hif.newpc !== ref_newpc()) begin
        tests_failed++;
        $display("FAIL newpc_rand[%0d]: got %h expected %h", i, hif.newpc, ref_newpc());
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_stalls();
    logic [3:0] want [4] = '{4'b1101, 4'b0000, 4'b0000, 4'b1101};
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      case (i)
        0: begin hif.memtoregE = 1'b1; hif.rtE = 5'd5; hif.rsD = 5'd5; end
        1: begin hif.rtE = 5'd5; hif.rsD = 5'd5; end
        2: begin hif.memtoregE = 1'b1; hif.rtE = 5'd0; hif.rsD = 5'd0; end
        default: begin hif.branchD = 1'b1; hif.rsD = 5'd4; hif.regwriteE = 1'b1; hif.writeregE = 5'd4; end
      endcase
      @(negedge clk);
      tests_run++;
      if ({hif.stallF, hif.stallD, hif.stallE, hif.flushE} !== want[i]) begin
        tests_failed++;
        $display("FAIL stall_case[%0d]: got %b expected %b", i,
                 {hif.stallF, hif.stallD, hif.stallE, hif.flushE}, want[i]);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  // one MDU op entering E now; result valid k cycles later (k > T means never)
  task automatic run_mdu(input int k);
    int r;
    logic st, bz, to, sp;
    logic [17:0] exp;
    clear_inputs();
    r = (k < T) ? k : T;
    for (int c = 0; c <= r + 1; c++) begin
      hif.mduopE    = 1'b1;
      hif.mdu_ready = (c == k) || (c == r + 1);
      @(negedge clk);
      st  = (c <= r);
      sp  = (c == 0);
      bz  = (c >= 1);
      to  = (k > T) && (c == T);
      exp = {6'b0, st, st, st, 5'b0, sp, 1'b0, bz, to};
      tests_run++;
      if (obs() !== exp) begin
        tests_failed++;
        $display("FAIL mdu_k%0d_c%0d: got %h expected %h", k, c, obs(), exp);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic check_idle(input string tag);
    clear_inputs();
    @(negedge clk);
    tests_run++;
    if (obs() !== 18'h0) begin
      tests_failed++;
      $display("FAIL %s: got %h expected 00000", tag, obs());
    end
    next_cycle();
  endtask

  task automatic test_mdu_latency();
    run_mdu(4);
    check_idle("mdu_latency_idle");
  endtask

  task automatic test_timeout();
    run_mdu(20);
    check_idle("mdu_timeout_idle");
  endtask

  task automatic test_exception();
    logic        mop [11] = '{1, 1, 1, 1, 0, 1, 0, 1, 1, 1, 0};
    logic        rdy [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [31:0] ex  [11] = '{0, 0, 0, 1, 0, 5, 0, 0, 0, 1, 0};
    logic [17:0] exp [11] = '{18'hE08, 18'hE02, 18'hE02, 18'h1F6, 18'h000, 18'h1F0,
                              18'h000, 18'hE08, 18'hE02, 18'h1F6, 18'h000};
    logic [31:0] pc;
    clear_inputs();
    for (int i = 0; i < 11; i++) begin
      hif.mduopE = mop[i]; hif.mdu_ready = rdy[i]; hif.excepttype = ex[i];
      @(negedge clk);
      pc = (ex[i] != 32'd0) ? 32'hBFC00380 : 32'd0;
      tests_run++;
      if (obs() !== exp[i] || hif.newpc !== pc) begin
        tests_failed++;
        $display("FAIL exception[%0d]: got %h/%h expected %h/%h", i, obs(), hif.newpc, exp[i], pc);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_eret();
    logic [31:0] pcs [2];
    pcs[0] = 32'h80001234;
    pcs[1] = $urandom;
    for (int i = 0; i < 2; i++) begin
      clear_inputs();
      hif.excepttype = 32'h0000000E;
      hif.epc = pcs[i];
      @(negedge clk);
      tests_run++;
      if (hif.newpc !== pcs[i] || obs() !== 18'h1F0) begin
        tests_failed++;
        $display("FAIL eret[%0d]: got %h/%h expected %h/001f0", i, hif.newpc, obs(), pcs[i]);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    logic [17:0] exp [5] = '{18'hE08, 18'hE02, 18'hE02, 18'h000, 18'h000};
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      hif.mduopE = (i < 4);
      rst = (i == 3);
      @(negedge clk);
      tests_run++;
      if (obs() !== exp[i]) begin
        tests_failed++;
        $display("FAIL reset_mid_busy[%0d]: got %h expected %h", i, obs(), exp[i]);
      end
      next_cycle();
    end
    rst = 1'b0;
    clear_inputs();
    // a fresh op after reset must see a cleared timeout counter
    run_mdu(20);
  endtask

  task automatic test_back_to_back();
    int k;
    run_mdu(2);
    run_mdu(3);
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(1, 11);
      if (k >= T) k = k + 1;
      run_mdu(k);
    end
    check_idle("back_to_back_idle");
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_stalls();
    test_mdu_latency();
    test_timeout();
    test_exception();
    test_eret();
    test_reset_mid_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
